// File: rtl/avgp_3x3_window_buffer.sv
// Line-buffered 3x3 dilated sliding window over a raster, plane-after-plane pixel stream.
// Optional feature macro AVGP_BUF_LAST_EN adds last_out marking the final window of each plane.
module avgp_3x3_window_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int KERNEL       = 3,
  parameter int RATE         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  stride2,
  output logic [DATA_WIDTH-1:0] pxl_out_00,
  output logic [DATA_WIDTH-1:0] pxl_out_01,
  output logic [DATA_WIDTH-1:0] pxl_out_02,
  output logic [DATA_WIDTH-1:0] pxl_out_03,
  output logic [DATA_WIDTH-1:0] pxl_out_04,
  output logic [DATA_WIDTH-1:0] pxl_out_05,
  output logic [DATA_WIDTH-1:0] pxl_out_06,
  output logic [DATA_WIDTH-1:0] pxl_out_07,
  output logic [DATA_WIDTH-1:0] pxl_out_08,
`ifdef AVGP_BUF_LAST_EN
  output logic                  last_out,
`endif
  output logic                  valid_out
);

  localparam int SPAN  = 2 * RATE;
  localparam int DEPTH = RATE * IMAGE_WIDTH;
  localparam int CW    = $clog2(IMAGE_WIDTH);
  localparam int RW    = $clog2(IMAGE_HEIGHT);
  localparam int PW    = $clog2(DEPTH);

  generate
    if (KERNEL != 3) begin : g_bad_kernel
      $fatal(1, "avgp_3x3_window_buffer supports KERNEL == 3 only");
    end
  endgenerate

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [PW-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0] r_lb1 [DEPTH];
  logic [DATA_WIDTH-1:0] r_lb2 [DEPTH];
  logic [DATA_WIDTH-1:0] r_sr  [3][SPAN];
  logic [DATA_WIDTH-1:0] r_tap [9];
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] w_lb1_q;
  logic [DATA_WIDTH-1:0] w_lb2_q;
  logic [DATA_WIDTH-1:0] w_row_in [3];
  logic [DATA_WIDTH-1:0] w_tap [9];
  logic                  w_complete;
  logic                  w_emit;
  logic                  w_col_wrap;
  logic                  w_row_wrap;

  // Both delay lines share one pointer: the slot read now was written DEPTH accepts ago.
  assign w_lb1_q     = r_lb1[r_ptr];
  assign w_lb2_q     = r_lb2[r_ptr];
  assign w_row_in[0] = w_lb2_q;
  assign w_row_in[1] = w_lb1_q;
  assign w_row_in[2] = pxl_in;

  assign w_col_wrap = (r_col == CW'(IMAGE_WIDTH - 1));
  assign w_row_wrap = (r_row == RW'(IMAGE_HEIGHT - 1));
  assign w_complete = valid_in && (r_row >= RW'(SPAN)) && (r_col >= CW'(SPAN));
  // Top-left row/col differ from the current ones by an even amount, so parity carries over.
  assign w_emit     = w_complete && (!stride2 || (!r_row[0] && !r_col[0]));

  // NOTE: always_comb assigns every element on every pass, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_tap[3*i + 0] = r_sr[i][SPAN-1];
      w_tap[3*i + 1] = r_sr[i][RATE-1];
      w_tap[3*i + 2] = w_row_in[i];
    end
  end

  // NOTE: storage arrays carry no reset; stale contents are never emitted because the
  // row/col counters gate every window.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_lb1[r_ptr] <= pxl_in;
      r_lb2[r_ptr] <= w_lb1_q;
      for (int i = 0; i < 3; i++) begin
        r_sr[i][0] <= w_row_in[i];
        for (int k = 1; k < SPAN; k++) begin
          r_sr[i][k] <= r_sr[i][k-1];
        end
      end
    end
  end

`ifdef AVGP_BUF_LAST_EN
  localparam int LAST_ROW_S2 = SPAN + ((IMAGE_HEIGHT - 1 - SPAN) / 2) * 2;
  localparam int LAST_COL_S2 = SPAN + ((IMAGE_WIDTH  - 1 - SPAN) / 2) * 2;

  logic r_last;
  logic w_last;

  assign w_last = stride2 ? ((r_row == RW'(LAST_ROW_S2)) && (r_col == CW'(LAST_COL_S2)))
                          : (w_row_wrap && w_col_wrap);
  assign last_out = r_last;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_tap[k] <= '0;
      end
`ifdef AVGP_BUF_LAST_EN
      r_last  <= 1'b0;
`endif
    end else begin
      r_valid <= w_emit;
`ifdef AVGP_BUF_LAST_EN
      r_last  <= w_emit && w_last;
`endif
      if (w_emit) begin
        for (int k = 0; k < 9; k++) begin
          r_tap[k] <= w_tap[k];
        end
      end
      if (valid_in) begin
        r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_wrap ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign valid_out  = r_valid;
  assign pxl_out_00 = r_tap[0];
  assign pxl_out_01 = r_tap[1];
  assign pxl_out_02 = r_tap[2];
  assign pxl_out_03 = r_tap[3];
  assign pxl_out_04 = r_tap[4];
  assign pxl_out_05 = r_tap[5];
  assign pxl_out_06 = r_tap[6];
  assign pxl_out_07 = r_tap[7];
  assign pxl_out_08 = r_tap[8];

endmodule

// File: tb/tb_avgp_3x3_window_buffer.sv
// Directed bench: 4x4/R=1 and 6x6/R=2 instances checked against hand-computed windows.
module tb_avgp_3x3_window_buffer;

  localparam int DW = 16;
  typedef logic [8:0][DW-1:0] taps_t;
  typedef struct packed {
    taps_t taps;
    logic  last;
    int    cyc;
  } win_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          v4 = 1'b0;
  logic          v6 = 1'b0;
  logic          s2 = 1'b0;
  logic [DW-1:0] pxl = '0;
  logic [DW-1:0] o4 [9];
  logic [DW-1:0] o6 [9];
  logic          vo4, vo6, lo4, lo6;

  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    acc[$];
  win_t  q4[$];
  win_t  q6[$];
  win_t  w_tmp;
  taps_t exp4 [4];
  taps_t exp6 [4];
  taps_t exp5 [8];
  int    cidx4 [4] = '{10, 11, 14, 15};
  int    cidx6 [4] = '{28, 29, 34, 35};

  avgp_3x3_window_buffer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL(3), .RATE(1)) u_dut4 (
    .clk(clk), .reset(reset), .valid_in(v4), .pxl_in(pxl), .stride2(s2),
    .pxl_out_00(o4[0]), .pxl_out_01(o4[1]), .pxl_out_02(o4[2]),
    .pxl_out_03(o4[3]), .pxl_out_04(o4[4]), .pxl_out_05(o4[5]),
    .pxl_out_06(o4[6]), .pxl_out_07(o4[7]), .pxl_out_08(o4[8]),
`ifdef AVGP_BUF_LAST_EN
    .last_out(lo4),
`endif
    .valid_out(vo4)
  );

  avgp_3x3_window_buffer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(6), .IMAGE_HEIGHT(6), .KERNEL(3), .RATE(2)) u_dut6 (
    .clk(clk), .reset(reset), .valid_in(v6), .pxl_in(pxl), .stride2(s2),
    .pxl_out_00(o6[0]), .pxl_out_01(o6[1]), .pxl_out_02(o6[2]),
    .pxl_out_03(o6[3]), .pxl_out_04(o6[4]), .pxl_out_05(o6[5]),
    .pxl_out_06(o6[6]), .pxl_out_07(o6[7]), .pxl_out_08(o6[8]),
`ifdef AVGP_BUF_LAST_EN
    .last_out(lo6),
`endif
    .valid_out(vo6)
  );

`ifndef AVGP_BUF_LAST_EN
  assign lo4 = 1'b0;
  assign lo6 = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic taps_t pack(input logic [DW-1:0] a [9]);
    taps_t t;
    for (int k = 0; k < 9; k++) t[k] = a[k];
    return t;
  endfunction

  function automatic taps_t w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  // Window capture, sampled on the falling edge away from register updates
  always @(negedge clk) begin
    if (vo4) begin
      w_tmp.taps = pack(o4); w_tmp.last = lo4; w_tmp.cyc = cyc;
      q4.push_back(w_tmp);
    end
    if (vo6) begin
      w_tmp.taps = pack(o6); w_tmp.last = lo6; w_tmp.cyc = cyc;
      q6.push_back(w_tmp);
    end
  end

  task automatic feed(input bit sel6, input int first, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pxl = DW'(first + k);
      if (sel6) v6 = 1'b1; else v4 = 1'b1;
      acc.push_back(cyc);
      if (gap) begin
        @(negedge clk);
        v4 = 1'b0; v6 = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    v4 = 1'b0; v6 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    q4.delete(); q6.delete(); acc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (vo4 !== 1'b0 || vo6 !== 1'b0) $display("FAIL reset_valid: got %b/%b want 0/0", vo4, vo6);
    else n_pass++;
    n_total++;
    if (pack(o4) !== '0 || pack(o6) !== '0) $display("FAIL reset_taps: got %h / %h want 0", pack(o4), pack(o6));
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_logs(); s2 = 1'b0;
    feed(1'b0, 1, 16, 1'b0);
    idle(4);
    n_total++;
    if (q4.size() !== 4) $display("FAIL t1_count: got %0d want 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_total++;
      if (q4[k].taps !== exp4[k]) $display("FAIL t1_win%0d: got %h want %h", k, q4[k].taps, exp4[k]);
      else n_pass++;
`ifdef AVGP_BUF_LAST_EN
      n_total++;
      if (q4[k].last !== (k == 3)) $display("FAIL t1_last%0d: got %b want %b", k, q4[k].last, (k == 3));
      else n_pass++;
`endif
    end
    if (q4.size() > 0) begin
      n_total++;
      if (q4[0].cyc !== acc[10] + 1) $display("FAIL t1_latency: got cycle %0d want %0d", q4[0].cyc, acc[10] + 1);
      else n_pass++;
    end
    n_total++;
    if (vo4 !== 1'b0 || pack(o4) !== exp4[3]) $display("FAIL t1_hold: got v=%b %h want v=0 %h", vo4, pack(o4), exp4[3]);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    clear_logs(); s2 = 1'b0;
    feed(1'b0, 1, 16, 1'b1);
    idle(4);
    n_total++;
    if (q4.size() !== 4) $display("FAIL t2_count: got %0d want 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_total++;
      if (q4[k].taps !== exp4[k]) $display("FAIL t2_win%0d: got %h want %h", k, q4[k].taps, exp4[k]);
      else n_pass++;
      n_total++;
      if (q4[k].cyc !== acc[cidx4[k]] + 1)
        $display("FAIL t2_timing%0d: got cycle %0d want %0d", k, q4[k].cyc, acc[cidx4[k]] + 1);
      else n_pass++;
    end
  endtask

  task automatic test_stride2();
    clear_logs(); s2 = 1'b1;
    feed(1'b0, 1, 16, 1'b0);
    idle(4);
    s2 = 1'b0;
    n_total++;
    if (q4.size() !== 1) $display("FAIL t3_count: got %0d want 1", q4.size());
    else n_pass++;
    if (q4.size() > 0) begin
      n_total++;
      if (q4[0].taps !== exp4[0]) $display("FAIL t3_win: got %h want %h", q4[0].taps, exp4[0]);
      else n_pass++;
`ifdef AVGP_BUF_LAST_EN
      n_total++;
      if (q4[0].last !== 1'b1) $display("FAIL t3_last: got %b want 1", q4[0].last);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_dilation();
    clear_logs(); s2 = 1'b0;
    feed(1'b1, 1, 36, 1'b0);
    idle(4);
    n_total++;
    if (q6.size() !== 4) $display("FAIL t4_count: got %0d want 4", q6.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q6.size(); k++) begin
      n_total++;
      if (q6[k].taps !== exp6[k]) $display("FAIL t4_win%0d: got %h want %h", k, q6[k].taps, exp6[k]);
      else n_pass++;
      n_total++;
      if (q6[k].cyc !== acc[cidx6[k]] + 1)
        $display("FAIL t4_timing%0d: got cycle %0d want %0d", k, q6[k].cyc, acc[cidx6[k]] + 1);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    clear_logs(); s2 = 1'b0;
    feed(1'b0, 1, 16, 1'b0);
    feed(1'b0, 101, 16, 1'b0);
    idle(4);
    n_total++;
    if (q4.size() !== 8) $display("FAIL t5_count: got %0d want 8", q4.size());
    else n_pass++;
    for (int k = 0; k < 8 && k < q4.size(); k++) begin
      n_total++;
      if (q4[k].taps !== exp5[k]) $display("FAIL t5_win%0d: got %h want %h", k, q4[k].taps, exp5[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_plane();
    clear_logs(); s2 = 1'b0;
    feed(1'b0, 1, 6, 1'b0);
    @(negedge clk);
    v4 = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (vo4 !== 1'b0 || pack(o4) !== '0) $display("FAIL t6_in_reset: got v=%b %h want v=0 0", vo4, pack(o4));
    else n_pass++;
    reset = 1'b1;
    clear_logs();
    feed(1'b0, 1, 16, 1'b0);
    idle(4);
    n_total++;
    if (q4.size() !== 4) $display("FAIL t6_count: got %0d want 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_total++;
      if (q4[k].taps !== exp4[k]) $display("FAIL t6_win%0d: got %h want %h", k, q4[k].taps, exp4[k]);
      else n_pass++;
    end
  endtask

  initial begin
    exp4[0] = w9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    exp4[1] = w9(2, 3, 4, 6, 7, 8, 10, 11, 12);
    exp4[2] = w9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    exp4[3] = w9(6, 7, 8, 10, 11, 12, 14, 15, 16);
    exp6[0] = w9(1, 3, 5, 13, 15, 17, 25, 27, 29);
    exp6[1] = w9(2, 4, 6, 14, 16, 18, 26, 28, 30);
    exp6[2] = w9(7, 9, 11, 19, 21, 23, 31, 33, 35);
    exp6[3] = w9(8, 10, 12, 20, 22, 24, 32, 34, 36);
    for (int k = 0; k < 4; k++) exp5[k] = exp4[k];
    exp5[4] = w9(101, 102, 103, 105, 106, 107, 109, 110, 111);
    exp5[5] = w9(102, 103, 104, 106, 107, 108, 110, 111, 112);
    exp5[6] = w9(105, 106, 107, 109, 110, 111, 113, 114, 115);
    exp5[7] = w9(106, 107, 108, 110, 111, 112, 114, 115, 116);

    test_reset();
    test_basic();
    test_bubbles();
    test_stride2();
    test_dilation();
    test_back_to_back();
    test_reset_mid_plane();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
